// File: rtl/nco.sv
// Numerically controlled oscillator: a 32-bit phase accumulator drives a
// quarter-wave folded, 13-rotation pipelined CORDIC with a fixed 14-edge latency.
module nco (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clken,
    input  logic        [31:0] phi_inc_i,
    output logic signed [11:0] fsin_o,
    output logic               out_valid
);

    localparam int ITER = 13;
    localparam int DW   = 18;

    // Start magnitude 32752/K, so the rotated vector peaks at 2047 in 4 fraction bits
    localparam logic signed [DW-1:0] X_INIT = 18'sd19889;

    // arctan(2^-i) where 2^16 units span a quarter turn
    function automatic logic signed [DW-1:0] atan_lut(input int i);
        case (i)
            1:       atan_lut = 18'sd19344;
            2:       atan_lut = 18'sd10221;
            3:       atan_lut = 18'sd5188;
            4:       atan_lut = 18'sd2604;
            5:       atan_lut = 18'sd1303;
            6:       atan_lut = 18'sd652;
            7:       atan_lut = 18'sd326;
            8:       atan_lut = 18'sd163;
            9:       atan_lut = 18'sd81;
            10:      atan_lut = 18'sd41;
            11:      atan_lut = 18'sd20;
            12:      atan_lut = 18'sd10;
            default: atan_lut = 18'sd0;
        endcase
    endfunction

    logic        [31:0]   acc;
    logic        [3:0]    fill_cnt;
    logic signed [DW-1:0] x_r [ITER];
    logic signed [DW-1:0] y_r [ITER];
    logic signed [DW-1:0] z_r [ITER];
    logic                 neg_r  [ITER];
    logic                 zero_r [ITER];

    logic        [1:0]    quad;
    logic        [15:0]   low;
    logic        [16:0]   ang;
    logic signed [DW-1:0] z_in;
    logic signed [DW-1:0] y_rnd;
    logic        [10:0]   mag;
    logic signed [11:0]   mag_s;
    logic signed [11:0]   fsin_n;
    logic                 valid_n;

    // Odd quadrants use the mirrored angle; a zero angle is flagged so the
    // zero crossings come out exactly 0 regardless of CORDIC residue.
    always_comb begin
        quad  = acc[31:30];
        low   = acc[29:14];
        ang   = quad[0] ? (17'h10000 - {1'b0, low}) : {1'b0, low};
        z_in  = signed'({1'b0, ang}) - 18'sd32768;
        y_rnd = (y_r[ITER-1] + 18'sd8) >>> 4;
        if (zero_r[ITER-1] || y_rnd < 0)
            mag = 11'd0;
        else if (y_rnd > 18'sd2047)
            mag = 11'd2047;
        else
            mag = y_rnd[10:0];
        mag_s   = {1'b0, mag};
        fsin_n  = neg_r[ITER-1] ? -mag_s : mag_s;
        valid_n = out_valid || (fill_cnt == 4'd13);
    end

    // Stage 0 folds the phase and performs the first (always positive) rotation
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc       <= '0;
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            fsin_o    <= '0;
            for (int k = 0; k < ITER; k++) begin
                x_r[k]    <= '0;
                y_r[k]    <= '0;
                z_r[k]    <= '0;
                neg_r[k]  <= 1'b0;
                zero_r[k] <= 1'b0;
            end
        end else if (clken) begin
            acc       <= acc + phi_inc_i;
            x_r[0]    <= X_INIT;
            y_r[0]    <= X_INIT;
            z_r[0]    <= z_in;
            neg_r[0]  <= quad[1];
            zero_r[0] <= (ang == 17'd0);
            for (int k = 1; k < ITER; k++) begin
                if (z_r[k-1] >= 0) begin
                    x_r[k] <= x_r[k-1] - (y_r[k-1] >>> k);
                    y_r[k] <= y_r[k-1] + (x_r[k-1] >>> k);
                    z_r[k] <= z_r[k-1] - atan_lut(k);
                end else begin
                    x_r[k] <= x_r[k-1] + (y_r[k-1] >>> k);
                    y_r[k] <= y_r[k-1] - (x_r[k-1] >>> k);
                    z_r[k] <= z_r[k-1] + atan_lut(k);
                end
                neg_r[k]  <= neg_r[k-1];
                zero_r[k] <= zero_r[k-1];
            end
            if (fill_cnt != 4'd13)
                fill_cnt <= fill_cnt + 4'd1;
            out_valid <= valid_n;
            fsin_o    <= valid_n ? fsin_n : 12'sd0;
        end
    end

endmodule

// File: tb/tb_nco.sv
// Self-checking bench for nco: a hand-computed vector table plus
// model-checked sequences for enable gaps, mid-stream reset and a full sweep.
module tb_nco;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               clken = 1'b0;
    logic        [31:0] phi_inc_i = '0;
    logic signed [11:0] fsin_o;
    logic               out_valid;

    int total = 0;
    int bad   = 0;

    // Reference model: accumulator and the phase entering the pipeline per edge
    logic [31:0] m_acc = '0;
    int          m_e   = 0;
    logic [31:0] hist [8192];

    typedef struct {
        logic        rn;
        logic        ce;
        logic [31:0] inc;
        logic        exp_valid;
        int          exp_fsin;
        int          tol;
    } vec_t;
    vec_t vecs[$];

    int sweep [4096];
    int sweep_min, sweep_max, asym, neg2048, rise;

    nco dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clken    (clken),
        .phi_inc_i(phi_inc_i),
        .fsin_o   (fsin_o),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic int sine_ref(input logic [31:0] p);
        real r;
        r = 2047.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 4294967296.0);
        return int'(r);
    endfunction

    task automatic addVec(input logic rn, input logic ce, input logic [31:0] inc,
                          input logic ev, input int ef, input int tol);
        vec_t v;
        v.rn = rn; v.ce = ce; v.inc = inc; v.exp_valid = ev; v.exp_fsin = ef; v.tol = tol;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic rn, input logic ce, input logic [31:0] inc);
        reset_n   = rn;
        clken     = ce;
        phi_inc_i = inc;
        @(posedge clk);
        #1;
        if (!rn) begin
            m_acc = '0;
            m_e   = 0;
        end else if (ce) begin
            m_e++;
            if (m_e < 8192) hist[m_e] = m_acc;
            m_acc = m_acc + inc;
        end
    endtask

    task automatic checkOutput(input string name);
        logic exp_v;
        int   exp_f, tol, diff;
        exp_v = (m_e >= 14);
        exp_f = exp_v ? sine_ref(hist[m_e - 13]) : 0;
        tol   = exp_v ? 2 : 0;
        total++;
        if (out_valid !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s valid edge=%0d got=%b want=%b", name, m_e, out_valid, exp_v);
        end
        total++;
        diff = int'(fsin_o) - exp_f;
        if (diff > tol || diff < -tol || fsin_o == -12'sd2048) begin
            bad++;
            $display("[TB] FAIL %s fsin edge=%0d got=%0d want=%0d+/-%0d", name, m_e, fsin_o, exp_f, tol);
        end
    endtask

    initial begin
        // Hand-computed quarter-rate table: phases 0, pi/2, pi, 3pi/2, ...
        addVec(1'b0, 1'b1, 32'h4000_0000, 1'b0, 0, 0);
        for (int i = 0; i < 13; i++)
            addVec(1'b1, 1'b1, 32'h4000_0000, 1'b0, 0, 0);
        addVec(1'b1, 1'b1, 32'h4000_0000, 1'b1, 0, 0);
        addVec(1'b1, 1'b1, 32'h4000_0000, 1'b1, 2047, 2);
        addVec(1'b1, 1'b1, 32'h4000_0000, 1'b1, 0, 0);
        addVec(1'b1, 1'b1, 32'h4000_0000, 1'b1, -2047, 2);
        addVec(1'b1, 1'b1, 32'h4000_0000, 1'b1, 0, 0);
        addVec(1'b1, 1'b0, 32'h4000_0000, 1'b1, 0, 0);
        addVec(1'b1, 1'b0, 32'h4000_0000, 1'b1, 0, 0);
        addVec(1'b1, 1'b0, 32'h4000_0000, 1'b1, 0, 0);
        addVec(1'b1, 1'b1, 32'h4000_0000, 1'b1, 2047, 2);
        addVec(1'b1, 1'b1, 32'h4000_0000, 1'b1, 0, 0);
        addVec(1'b1, 1'b1, 32'h4000_0000, 1'b1, -2047, 2);
        addVec(1'b0, 1'b1, 32'h4000_0000, 1'b0, 0, 0);
        addVec(1'b1, 1'b1, 32'h4000_0000, 1'b0, 0, 0);

        foreach (vecs[i]) begin
            int diff;
            applyStimulus(vecs[i].rn, vecs[i].ce, vecs[i].inc);
            total++;
            if (out_valid !== vecs[i].exp_valid) begin
                bad++;
                $display("[TB] FAIL vec%0d valid got=%b want=%b", i, out_valid, vecs[i].exp_valid);
            end
            total++;
            diff = int'(fsin_o) - vecs[i].exp_fsin;
            if (diff > vecs[i].tol || diff < -vecs[i].tol) begin
                bad++;
                $display("[TB] FAIL vec%0d fsin got=%0d want=%0d+/-%0d", i, fsin_o, vecs[i].exp_fsin, vecs[i].tol);
            end
        end

        // Period-80 stream with a 5-cycle enable gap in the middle
        applyStimulus(1'b0, 1'b1, 32'h0333_3333);
        checkOutput("p80_reset");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0333_3333);
            checkOutput("p80");
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0333_3333);
            checkOutput("p80_hold");
        end
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0333_3333);
            checkOutput("p80_resume");
        end

        // One-cycle reset mid-stream, then an enable gap before out_valid rises
        applyStimulus(1'b0, 1'b1, 32'h0333_3333);
        checkOutput("midreset");
        rise = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0333_3333);
            rise++;
            checkOutput("gap_pre");
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0333_3333);
            rise++;
            checkOutput("gap_off");
        end
        while (!out_valid && rise < 40) begin
            applyStimulus(1'b1, 1'b1, 32'h0333_3333);
            rise++;
            checkOutput("gap_post");
        end
        total++;
        if (rise != 19) begin
            bad++;
            $display("[TB] FAIL valid_rise got=%0d want=19", rise);
        end

        // Sweep past the accumulator wrap; index samples by pipeline phase
        applyStimulus(1'b0, 1'b1, 32'h0010_0000);
        sweep_min = 0; sweep_max = 0; neg2048 = 0;
        for (int i = 0; i < 4400; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0010_0000);
            checkOutput("sweep");
            if (m_e >= 14 && m_e - 14 < 4096) sweep[m_e - 14] = int'(fsin_o);
            if (int'(fsin_o) < sweep_min) sweep_min = int'(fsin_o);
            if (int'(fsin_o) > sweep_max) sweep_max = int'(fsin_o);
            if (fsin_o == -12'sd2048) neg2048++;
        end
        asym = 0;
        for (int k = 0; k < 2048; k++)
            if (sweep[k] != -sweep[k + 2048]) asym++;
        total++;
        if (asym != 0) begin
            bad++;
            $display("[TB] FAIL odd_symmetry got=%0d asymmetric pairs want=0", asym);
        end
        total++;
        if (sweep_max < 2045 || sweep_max > 2047) begin
            bad++;
            $display("[TB] FAIL sweep_max got=%0d want=2045..2047", sweep_max);
        end
        total++;
        if (sweep_min > -2045 || sweep_min < -2047) begin
            bad++;
            $display("[TB] FAIL sweep_min got=%0d want=-2047..-2045", sweep_min);
        end
        total++;
        if (neg2048 != 0) begin
            bad++;
            $display("[TB] FAIL no_neg2048 got=%0d want=0", neg2048);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nco.md
Name: nco

Overview:
- Numerically controlled oscillator producing a 12-bit signed sine wave from a 32-bit phase-increment word.
- A 32-bit phase accumulator advances by phi_inc_i on every enabled clock.
- A fixed-latency sine generator (pipelined CORDIC or folded quarter-wave LUT; implementer's choice) maps the accumulator phase to amplitude.
- Feeds DAC/mixer datapaths; output frequency = phi_inc_i * f_clk / 2^32.

Parameters:
- None. Widths are fixed: phase 32 bits, output 12 bits, latency 14 enabled clocks.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- clken  input  1  clock enable; when low, every register holds.
- phi_inc_i  input  32  unsigned phase increment; sampled on every enabled edge and may change at any time.
- fsin_o  output  12  two's-complement sine sample.
- out_valid  output  1  high once the pipeline holds valid data.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - accumulator, all pipeline registers, fsin_o and out_valid all go to 0.
  - Reset takes priority over clken.
  - Reset applied mid-operation discards all in-flight samples.
- Enabled edge (reset_n=1, clken=1):
  - acc <= acc + phi_inc_i, modulo 2^32; wrap-around is silent.
  - The pre-increment acc value enters the sine pipeline.
- Disabled edge (clken=0): accumulator, pipeline, fsin_o and out_valid all hold their values.
- Phase sequence after reset: pipeline inputs are 0, P0, P0+P1, ..., where Pi is phi_inc_i at the i-th enabled edge.
- Latency: the phase captured at enabled edge n appears on fsin_o after enabled edge n+13, i.e. 14 enabled edges total.
  - The first valid sample is therefore sin(0) = 0.
- out_valid:
  - An internal counter counts enabled edges since reset release.
  - out_valid is registered high on the 14th enabled edge, coincident with the first valid fsin_o, and then stays high until the next reset.
  - fsin_o is 0 while out_valid is low.
- Amplitude mapping:
  - fsin_o = round(2047 * sin(2*pi*phase/2^32)), with tolerance of +/-2 LSB.
  - Output is saturated to the range -2047..+2047; -2048 is never produced.
- Phase resolution: at least the top 14 bits of the phase are used; lower bits are truncated.
- Symmetry:
  - Top 2 phase bits select the quadrant.
  - Quadrants 1 and 3 use the mirrored phase.
  - Quadrants 2 and 3 negate the result.
  - The output must be exactly odd-symmetric: sample(phase) = -sample(phase + 2^31) for identical lower bits.
- CORDIC option: at least 12 iterations, internal datapath at least 16 bits; pre-scale the start vector by 1/K so that peak = 2047; pad with register stages to reach exactly 14.
- phi_inc_i = 0: output holds the constant sin(acc) of the frozen accumulator, which is 0 after reset.
- phi_inc_i = 2^31: output alternates 0, 0 (Nyquist; phases 0 and pi).
- Changing phi_inc_i mid-stream causes a phase-continuous frequency change, with no discontinuity in acc.

Test Plan:
- Reset then phi_inc_i = 0x03333333, clken = 1 -> out_valid rises on the 14th edge after reset release.
  - Valid samples then trace a period of ~80: sample 0 = 0, sample 20 = 2047 (+/-2), sample 40 = 0 (+/-2), sample 60 = -2047 (+/-2).
  - Every sample k is within +/-2 LSB of round(2047*sin(2*pi*k*0x03333333/2^32)).
- phi_inc_i = 0x40000000 -> valid samples repeat 0, 2047, 0, -2047 (each +/-2).
- Toggle clken low for 5 cycles mid-stream -> fsin_o and out_valid are frozen.
  - On resume, the sequence continues with no skipped or duplicated sample.
  - The out_valid rise is delayed by exactly the number of disabled cycles if the toggle happens before it.
- Assert reset_n = 0 for 1 cycle while streaming -> next edge has fsin_o = 0 and out_valid = 0.
  - The sequence restarts from phase 0 with the 14-cycle fill.
- Sweep phi_inc_i = 0x00100000 over more than one full period, including acc wrap past 2^32 -> no glitch at the wrap.
  - Odd symmetry holds; min = -2047 and max = +2047 (+/-2); the value -2048 never appears.
